// File: rtl/csr_enc_mul_pkg.sv
// Shared types, bounds and saturation helper for the csr_enc multiply / MAC pipe.
// Latency: n/a (package).
// Backpressure: n/a (package).
package csr_enc_mul_pkg;

  // Legal bounds for the total pipe latency (in ce-cycles).
  localparam int NUM_STAGE_MIN = 2;
  localparam int NUM_STAGE_MAX = 8;

  // Widest value the saturation helper accepts.
  localparam int SAT_MAX_W = 64;

  // Sideband carried alongside each sample through the pipe.
  typedef struct packed {
    logic valid;
    logic acc_en;
    logic acc_clr;
  } mul_sb_t;

  // Clamp a pre-extended value to an out_w-bit range.
  // val must already be sign- or zero-extended to SAT_MAX_W bits.
  // Returns {ovf, clamped}; only the low out_w bits of clamped matter.
  function automatic logic [SAT_MAX_W:0] sat_clamp(
    input logic [SAT_MAX_W-1:0] val,
    input int                   out_w,
    input logic                 is_signed
  );
    logic [SAT_MAX_W-1:0] hi;
    logic [SAT_MAX_W-1:0] lo;
    logic [SAT_MAX_W-1:0] res;
    logic                 ovf;
    hi  = '0;
    lo  = '0;
    res = val;
    ovf = 1'b0;
    if (is_signed) begin
      hi = (SAT_MAX_W'(1) << (out_w - 1)) - SAT_MAX_W'(1);
      lo = ~hi;  // -2^(out_w-1) in SAT_MAX_W-bit two's complement
      if ($signed(val) > $signed(hi)) begin
        res = hi;
        ovf = 1'b1;
      end else if ($signed(val) < $signed(lo)) begin
        res = lo;
        ovf = 1'b1;
      end
    end else begin
      hi = (out_w >= SAT_MAX_W) ? '1 : (SAT_MAX_W'(1) << out_w) - SAT_MAX_W'(1);
      if (val > hi) begin
        res = hi;
        ovf = 1'b1;
      end
    end
    return {ovf, res};
  endfunction

endpackage

// File: rtl/csr_enc_mul_core.sv
// Multiplier core: operand register, product, NUM_STAGE-2 product pipe stages, sideband alongside.
// Latency: NUM_STAGE-1 ce-edges from operand capture to the prod_o/sb_o stage.
// Backpressure: none; ce_i low freezes every register.
// Ports: clk, reset (sync, active-high), ce_i, vld_i/acc_en_i/acc_clr_i sideband in,
//        a_i/b_i operands, prod_o full-width product, sb_o sideband matching prod_o.
module csr_enc_mul_core
  import csr_enc_mul_pkg::*;
#(
  parameter int DIN0_WIDTH = 14,
  parameter int DIN1_WIDTH = 14,
  parameter int NUM_STAGE  = 4,
  parameter int SIGNED     = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             ce_i,
  input  logic                             vld_i,
  input  logic                             acc_en_i,
  input  logic                             acc_clr_i,
  input  logic [DIN0_WIDTH-1:0]            a_i,
  input  logic [DIN1_WIDTH-1:0]            b_i,
  output logic [DIN0_WIDTH+DIN1_WIDTH-1:0] prod_o,
  output mul_sb_t                          sb_o
);

  localparam int PW = DIN0_WIDTH + DIN1_WIDTH;

  logic [DIN0_WIDTH-1:0] a_q;
  logic [DIN1_WIDTH-1:0] b_q;
  mul_sb_t               sb_q;
  logic [PW-1:0]         a_ext;
  logic [PW-1:0]         b_ext;
  logic [PW-1:0]         prod_c;

  // Operand stage (first of the NUM_STAGE registers).
  always_ff @(posedge clk) begin
    if (reset) begin
      sb_q <= '0;
    end else if (ce_i) begin
      a_q          <= a_i;
      b_q          <= b_i;
      sb_q.valid   <= vld_i;
      sb_q.acc_en  <= acc_en_i;
      sb_q.acc_clr <= acc_clr_i & acc_en_i;  // clear is meaningless outside MAC mode
    end
  end

  // Extending both operands to the full product width lets a plain
  // unsigned PW x PW multiply yield the correct low PW bits for either signedness.
  generate
    if (SIGNED != 0) begin : g_sext
      assign a_ext = PW'($signed(a_q));
      assign b_ext = PW'($signed(b_q));
    end else begin : g_zext
      assign a_ext = PW'(a_q);
      assign b_ext = PW'(b_q);
    end
  endgenerate

  assign prod_c = a_ext * b_ext;

  generate
    if (NUM_STAGE <= 2) begin : g_no_pipe
      assign prod_o = prod_c;
      assign sb_o   = sb_q;
    end else begin : g_pipe
      localparam int D = NUM_STAGE - 2;
      logic [PW-1:0] prod_q [D];
      mul_sb_t       psb_q  [D];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < D; i++) psb_q[i] <= '0;
        end else if (ce_i) begin
          prod_q[0] <= prod_c;
          psb_q[0]  <= sb_q;
          for (int i = 1; i < D; i++) begin
            prod_q[i] <= prod_q[i-1];
            psb_q[i]  <= psb_q[i-1];
          end
        end
      end

      assign prod_o = prod_q[D-1];
      assign sb_o   = psb_q[D-1];
    end
  endgenerate

endmodule

// File: rtl/csr_enc_mac_pipe.sv
// Pipelined multiply / multiply-accumulate unit; optional saturation via macro CSR_ENC_MUL_SAT_EN.
// Latency: NUM_STAGE ce-cycles, one sample per ce-cycle, accumulator updated in the final stage.
// Backpressure: none; ce low freezes all state and holds dout/out_valid/ovf.
// Ports: clk, reset (sync, active-high, beats ce), ce, in_valid, acc_en, acc_clr,
//        din0/din1 operands, dout result, out_valid result strobe, ovf saturation flag.
module csr_enc_mac_pipe
  import csr_enc_mul_pkg::*;
#(
  parameter int DIN0_WIDTH = 14,
  parameter int DIN1_WIDTH = 14,
  parameter int DOUT_WIDTH = 14,
  parameter int ACC_WIDTH  = 32,
  parameter int NUM_STAGE  = 4,
  parameter int SIGNED     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic                  acc_en,
  input  logic                  acc_clr,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  out_valid,
  output logic                  ovf
);

  localparam int PW = DIN0_WIDTH + DIN1_WIDTH;

  generate
    if (NUM_STAGE < NUM_STAGE_MIN || NUM_STAGE > NUM_STAGE_MAX) begin : g_bad_stage
      $error("csr_enc_mac_pipe: NUM_STAGE out of range 2..8");
    end
    if (ACC_WIDTH < PW) begin : g_bad_acc
      $error("csr_enc_mac_pipe: ACC_WIDTH must be >= DIN0_WIDTH+DIN1_WIDTH");
    end
    if (DOUT_WIDTH > ACC_WIDTH) begin : g_bad_dout
      $error("csr_enc_mac_pipe: DOUT_WIDTH must be <= ACC_WIDTH");
    end
  endgenerate

  logic [PW-1:0]         prod;
  mul_sb_t               sb;
  logic [ACC_WIDTH-1:0]  prod_ext;
  logic [ACC_WIDTH-1:0]  acc_sum;
  logic [ACC_WIDTH-1:0]  res;
  logic [ACC_WIDTH-1:0]  acc_d;
  logic [ACC_WIDTH-1:0]  acc_q;
  logic [DOUT_WIDTH-1:0] dout_d;
  logic [DOUT_WIDTH-1:0] dout_q;
  logic                  out_valid_q;

  csr_enc_mul_core #(
    .DIN0_WIDTH (DIN0_WIDTH),
    .DIN1_WIDTH (DIN1_WIDTH),
    .NUM_STAGE  (NUM_STAGE),
    .SIGNED     (SIGNED)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .ce_i      (ce),
    .vld_i     (in_valid),
    .acc_en_i  (acc_en),
    .acc_clr_i (acc_clr),
    .a_i       (din0),
    .b_i       (din1),
    .prod_o    (prod),
    .sb_o      (sb)
  );

  generate
    if (SIGNED != 0) begin : g_sext
      assign prod_ext = ACC_WIDTH'($signed(prod));
    end else begin : g_zext
      assign prod_ext = ACC_WIDTH'(prod);
    end
  endgenerate

  // Accumulate lives in the output stage, so back-to-back MAC samples
  // always see the previous sample's sum with no forwarding needed.
  always_comb begin
    acc_sum = sb.acc_clr ? prod_ext : (acc_q + prod_ext);
    res     = sb.acc_en ? acc_sum : prod_ext;
    acc_d   = acc_q;
    if (sb.valid && sb.acc_en) acc_d = acc_sum;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
    end else if (ce) begin
      acc_q       <= acc_d;
      out_valid_q <= sb.valid;
      if (sb.valid) dout_q <= dout_d;
    end
  end

`ifdef CSR_ENC_MUL_SAT_EN
  generate
    if (ACC_WIDTH > SAT_MAX_W) begin : g_bad_sat
      $error("csr_enc_mac_pipe: ACC_WIDTH too wide for saturation");
    end
  endgenerate

  logic [SAT_MAX_W-1:0] res_w;
  logic [SAT_MAX_W:0]   sat_r;
  logic                 ovf_d;
  logic                 ovf_q;

  generate
    if (SIGNED != 0) begin : g_res_sext
      assign res_w = SAT_MAX_W'($signed(res));
    end else begin : g_res_zext
      assign res_w = SAT_MAX_W'(res);
    end
    if (DOUT_WIDTH < SAT_MAX_W) begin : g_sat_hi
      logic unused_sat_hi;
      assign unused_sat_hi = ^sat_r[SAT_MAX_W-1:DOUT_WIDTH];
    end
  endgenerate

  assign sat_r  = sat_clamp(res_w, DOUT_WIDTH, SIGNED != 0);
  assign dout_d = sat_r[DOUT_WIDTH-1:0];
  assign ovf_d  = sat_r[SAT_MAX_W];

  // Cleared on any ce-cycle without a result, so it pulses with out_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (ce) begin
      ovf_q <= sb.valid & ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  generate
    if (ACC_WIDTH > DOUT_WIDTH) begin : g_trunc_hi
      logic unused_res_hi;
      assign unused_res_hi = ^res[ACC_WIDTH-1:DOUT_WIDTH];
    end
  endgenerate

  assign dout_d = res[DOUT_WIDTH-1:0];
  assign ovf    = 1'b0;
`endif

  assign dout      = dout_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_csr_enc_mac_pipe.sv
// Self-checking bench for csr_enc_mac_pipe: directed scenarios plus randomized traffic vs a reference model.
// Latency: model predicts each result at accept ce-edge + NUM_STAGE-1.
// Backpressure: ce stalls and resets are mixed into the stimulus.
module tb_csr_enc_mac_pipe;

  localparam int N = 4;

  logic        clk;
  logic        reset;
  logic        ce;
  logic        in_valid;
  logic        acc_en;
  logic        acc_clr;
  logic [13:0] din0;
  logic [13:0] din1;
  logic [13:0] dout;
  logic        out_valid;
  logic        ovf;

  logic        u_in_valid;
  logic [7:0]  u_din0;
  logic [7:0]  u_din1;
  logic [15:0] u_dout;
  logic        u_out_valid;
  logic        u_ovf;

  csr_enc_mac_pipe u_dut (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .in_valid  (in_valid),
    .acc_en    (acc_en),
    .acc_clr   (acc_clr),
    .din0      (din0),
    .din1      (din1),
    .dout      (dout),
    .out_valid (out_valid),
    .ovf       (ovf)
  );

  csr_enc_mac_pipe #(
    .DIN0_WIDTH (8),
    .DIN1_WIDTH (8),
    .DOUT_WIDTH (16),
    .SIGNED     (0)
  ) u_dut_uns (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .in_valid  (u_in_valid),
    .acc_en    (1'b0),
    .acc_clr   (1'b0),
    .din0      (u_din0),
    .din1      (u_din1),
    .dout      (u_dout),
    .out_valid (u_out_valid),
    .ovf       (u_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    logic [15:0] dat;
    logic        ovf;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        uexp_q[$];
  int unsigned edge_cnt;
  logic [31:0] acc_m;
  logic        exp_ov;
  logic [13:0] exp_dout;
  logic        exp_ovf;
  logic        uexp_ov;
  logic [15:0] uexp_dout;
  int          n_tests;
  int          n_fail;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, edge_cnt);
    end
  endtask

  // Expected dout/ovf for one accepted sample, computed with plain integer arithmetic.
  function automatic exp_t model_sample(input logic ae, input logic ac,
                                        input logic [13:0] a, input logic [13:0] b);
    exp_t   e;
    longint p;
    longint r;
    p = longint'($signed(a)) * longint'($signed(b));
    if (ae) begin
      if (ac) acc_m = p[31:0];
      else    acc_m = acc_m + p[31:0];
      r = longint'($signed(acc_m));
    end else begin
      r = p;
    end
    e.due = 0;
`ifdef CSR_ENC_MUL_SAT_EN
    if (r > 8191) begin
      e.dat = 16'h1FFF;
      e.ovf = 1'b1;
    end else if (r < -8192) begin
      e.dat = 16'h2000;
      e.ovf = 1'b1;
    end else begin
      e.dat = {2'b00, r[13:0]};
      e.ovf = 1'b0;
    end
`else
    e.dat = {2'b00, r[13:0]};
    e.ovf = 1'b0;
`endif
    return e;
  endfunction

  task automatic step(input logic rst, input logic c, input logic v, input logic ae,
                      input logic ac, input logic [13:0] a, input logic [13:0] b);
    exp_t e;
    reset    = rst;
    ce       = c;
    in_valid = v;
    acc_en   = ae;
    acc_clr  = ac;
    din0     = a;
    din1     = b;
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      uexp_q.delete();
      acc_m     = '0;
      exp_ov    = 1'b0;
      exp_dout  = '0;
      exp_ovf   = 1'b0;
      uexp_ov   = 1'b0;
      uexp_dout = '0;
    end else if (c) begin
      edge_cnt++;
      if (v) begin
        e = model_sample(ae, ae & ac, a, b);
        e.due = edge_cnt + N - 1;
        exp_q.push_back(e);
      end
      if (u_in_valid) begin
        e.due = edge_cnt + N - 1;
        e.dat = 16'(u_din0) * 16'(u_din1);
        e.ovf = 1'b0;
        uexp_q.push_back(e);
      end
      exp_ov  = 1'b0;
      exp_ovf = 1'b0;
      uexp_ov = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].due == edge_cnt) begin
        e        = exp_q.pop_front();
        exp_ov   = 1'b1;
        exp_dout = e.dat[13:0];
        exp_ovf  = e.ovf;
      end
      if (uexp_q.size() > 0 && uexp_q[0].due == edge_cnt) begin
        e         = uexp_q.pop_front();
        uexp_ov   = 1'b1;
        uexp_dout = e.dat;
      end
    end
    check_eq("out_valid", 32'(out_valid), 32'(exp_ov));
    check_eq("dout", 32'(dout), 32'(exp_dout));
    check_eq("ovf", 32'(ovf), 32'(exp_ovf));
    check_eq("u_out_valid", 32'(u_out_valid), 32'(uexp_ov));
    check_eq("u_dout", 32'(u_dout), 32'(uexp_dout));
    check_eq("u_ovf", 32'(u_ovf), 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 14'd0, 14'd0);
  endtask

  logic [13:0] ra;
  logic [13:0] rb;

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    edge_cnt   = 0;
    acc_m      = '0;
    u_in_valid = 1'b0;
    u_din0     = '0;
    u_din1     = '0;

    // Reset state
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 14'd0, 14'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 14'd0, 14'd0);

    // -3 x 5 multiply
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, -14'sd3, 14'd5);
    idle(5);

    // 200 x 100 overflows a 14-bit result
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 14'd200, 14'd100);
    idle(5);

    // MAC stream back-to-back
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 14'd2, 14'd3);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 14'd4, 14'd5);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 14'd1, 14'd1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 14'd7, 14'd1);
    idle(5);

    // Same stream with a 3-cycle stall mid-pipeline and bubbles
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 14'd2, 14'd3);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 14'd9, 14'd9);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 14'd4, 14'd5);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 14'd8, 14'd8);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'd0, 14'd0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 14'd3, 14'd3);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 14'd1, 14'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 14'd0, 14'd0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 14'd7, 14'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'd0, 14'd0);
    idle(6);

    // acc_clr without acc_en is a plain multiply and leaves the sum alone
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 14'd6, 14'd6);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 14'd1, 14'd2);
    idle(5);

    // Reset two cycles after accepting 9 x 9
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 14'd9, 14'd9);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 14'd0, 14'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 14'd0, 14'd0);
    idle(2);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 14'd2, 14'd2);
    idle(5);

    // Unsigned 8x8 -> 16 instance: 255 x 255
    u_in_valid = 1'b1;
    u_din0     = 8'd255;
    u_din1     = 8'd255;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 14'd0, 14'd0);
    u_in_valid = 1'b0;
    u_din0     = 8'd0;
    u_din1     = 8'd0;
    idle(5);

    // Randomized traffic with stalls and occasional resets
    for (int i = 0; i < 600; i++) begin
      ra = 14'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 14'($urandom_range(0, 7)) : 14'($urandom);
      step(($urandom_range(0, 149) == 0),
           ($urandom_range(0, 4) != 0),
           ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0),
           ra, rb);
    end
    idle(8);

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d results never appeared, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
